// File: rtl/instr_seq_fsm_v2.sv
// Instruction sequencer: fetches one opcode per pass and drives AXI read/write launches,
// the delay counter, compare retries, interrupt waits and HALT, with a watchdog on every wait.
module instr_seq_fsm_v2 #(
    parameter int CNT_W      = 7,
    parameter int FETCH_LAT  = 1,
    parameter int TMO_W      = 16,
    parameter int TMO_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       opcode,
    input  logic [CNT_W-1:0] count,
    input  logic             done_rd,
    input  logic             done_wr,
    input  logic             done_delay,
    input  logic             pass_cmp,
    input  logic             intr_edge,
    input  logic             resume,
    input  logic             err_clr,
    output logic             start_rd,
    output logic             start_wr,
    output logic             en_mem_rd,
    output logic             en_pc,
    output logic             en_delay_count,
    output logic [CNT_W-1:0] exec_count,
    output logic             done_instr,
    output logic             busy,
    output logic             halted,
    output logic             err_timeout,
    output logic             err_retry,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_FETCH       = 4'd1,
        S_WAIT_FETCH  = 4'd2,
        S_START       = 4'd3,
        S_EXEC        = 4'd4,
        S_COUNT_CHECK = 4'd5,
        S_FLAG_CHECK  = 4'd6,
        S_DONE        = 4'd7,
        S_HALT        = 4'd8,
        S_ERROR       = 4'd9
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_WRCMD = 3'b011;
    localparam logic [2:0] OP_DELAY = 3'b100;
    localparam logic [2:0] OP_CMP   = 3'b101;
    localparam logic [2:0] OP_WAIT  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int               FW      = (FETCH_LAT > 1) ? $clog2(FETCH_LAT + 1) : 1;
    localparam logic [FW-1:0]    FETCH_LD = FW'(FETCH_LAT);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TMO_CYCLES);
    localparam bit               TMO_EN   = (TMO_CYCLES != 0);

    state_t           state_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] exec_cnt_q;
    logic [TMO_W-1:0] timer_q;
    logic [FW-1:0]    fetch_cnt_q;
    logic             err_tmo_q;
    logic             err_retry_q;

    logic             done_x;
    logic [TMO_W-1:0] timer_d;
    logic             tmo_hit;
    logic [CNT_W-1:0] exec_cnt_d;
    logic             op_counts;
    logic             opcode_counts;

    // timer_d is the value the watchdog holds after this cycle; a timeout fires
    // on the cycle that would bring it to the limit, unless a completion arrives.
    always_comb begin
        done_x        = done_rd | done_wr | done_delay;
        timer_d       = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        tmo_hit       = TMO_EN && (timer_d == TMO_LIM);
        exec_cnt_d    = (exec_cnt_q == '0) ? exec_cnt_q : exec_cnt_q - 1'b1;
        op_counts     = (op_q == OP_READ) || (op_q == OP_WRITE) || (op_q == OP_CMP);
        opcode_counts = (opcode == OP_READ) || (opcode == OP_WRITE) || (opcode == OP_CMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            exec_cnt_q  <= '0;
            timer_q     <= '0;
            fetch_cnt_q <= '0;
            err_tmo_q   <= 1'b0;
            err_retry_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    fetch_cnt_q <= FETCH_LD;
                    state_q     <= S_WAIT_FETCH;
                end
                S_WAIT_FETCH: begin
                    if (fetch_cnt_q != '0) fetch_cnt_q <= fetch_cnt_q - 1'b1;
                    if (fetch_cnt_q <= FW'(1)) begin
                        op_q    <= opcode;
                        if (opcode_counts) exec_cnt_q <= count;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    timer_q <= '0;
                    case (op_q)
                        OP_WAIT: state_q <= S_FLAG_CHECK;
                        OP_HALT: state_q <= S_HALT;
                        OP_NOP:  state_q <= S_DONE;
                        default: state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    timer_q <= timer_d;
                    if (done_x) begin
                        if (op_counts) exec_cnt_q <= exec_cnt_d;
                        case (op_q)
                            OP_READ, OP_WRITE: state_q <= S_COUNT_CHECK;
                            OP_CMP:            state_q <= S_FLAG_CHECK;
                            default:           state_q <= S_DONE;
                        endcase
                    end else if (tmo_hit) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= S_ERROR;
                    end
                end
                S_COUNT_CHECK: begin
                    state_q <= (exec_cnt_q != '0) ? S_START : S_DONE;
                end
                S_FLAG_CHECK: begin
                    if (op_q == OP_CMP) begin
                        if (pass_cmp) begin
                            state_q <= S_DONE;
                        end else if (exec_cnt_q != '0) begin
                            state_q <= S_START;
                        end else begin
                            err_retry_q <= 1'b1;
                            state_q     <= S_ERROR;
                        end
                    end else begin
                        timer_q <= timer_d;
                        if (intr_edge) begin
                            state_q <= S_DONE;
                        end else if (tmo_hit) begin
                            err_tmo_q <= 1'b1;
                            state_q   <= S_ERROR;
                        end
                    end
                end
                S_HALT: begin
                    if (resume) state_q <= S_DONE;
                end
                S_ERROR: begin
                    // Clearing retires the faulting instruction so the program moves on.
                    if (err_clr) begin
                        err_tmo_q   <= 1'b0;
                        err_retry_q <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode: every output depends only on registered state and op_q.
    always_comb begin
        start_rd       = 1'b0;
        start_wr       = 1'b0;
        en_mem_rd      = 1'b0;
        en_pc          = 1'b0;
        en_delay_count = 1'b0;
        done_instr     = 1'b0;
        halted         = 1'b0;
        case (state_q)
            S_FETCH: en_pc = 1'b1;
            S_START: begin
                start_rd       = (op_q == OP_READ) || (op_q == OP_CMP);
                start_wr       = (op_q == OP_WRITE) || (op_q == OP_WRCMD);
                en_delay_count = (op_q == OP_DELAY);
            end
            S_EXEC: begin
                en_mem_rd      = 1'b1;
                en_delay_count = (op_q == OP_DELAY);
            end
            S_DONE: done_instr = 1'b1;
            S_HALT: halted     = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign exec_count  = exec_cnt_q;
    assign err_timeout = err_tmo_q;
    assign err_retry   = err_retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_seq_fsm_v2.sv
// Directed bench for instr_seq_fsm_v2 (TMO_CYCLES=20): expected exec_count values are
// queued when each instruction is issued and popped at every launch pulse.
module tb_instr_seq_fsm_v2;

    localparam int CNT_W = 7;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [2:0]       opcode;
    logic [CNT_W-1:0] count;
    logic             done_rd, done_wr, done_delay, pass_cmp, intr_edge, resume, err_clr;
    logic             start_rd, start_wr, en_mem_rd, en_pc, en_delay_count;
    logic [CNT_W-1:0] exec_count;
    logic             done_instr, busy, halted, err_timeout, err_retry;
    logic [3:0]       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    logic [CNT_W-1:0] exp_q[$];

    instr_seq_fsm_v2 #(
        .CNT_W(CNT_W), .FETCH_LAT(1), .TMO_W(16), .TMO_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .opcode(opcode), .count(count),
        .done_rd(done_rd), .done_wr(done_wr), .done_delay(done_delay),
        .pass_cmp(pass_cmp), .intr_edge(intr_edge), .resume(resume), .err_clr(err_clr),
        .start_rd(start_rd), .start_wr(start_wr), .en_mem_rd(en_mem_rd), .en_pc(en_pc),
        .en_delay_count(en_delay_count), .exec_count(exec_count), .done_instr(done_instr),
        .busy(busy), .halted(halted), .err_timeout(err_timeout), .err_retry(err_retry),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_rd) rd_pulses++;
        if (start_wr) wr_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] outs_vec();
        return {start_rd, start_wr, en_mem_rd, en_pc, en_delay_count,
                done_instr, busy, halted, err_timeout, err_retry};
    endfunction

    task automatic wait_state(input logic [3:0] s, input string tag);
        int n = 0;
        while (state_dbg !== s && n < 100) begin
            step();
            n++;
        end
        check(tag, {28'd0, state_dbg}, {28'd0, s});
    endtask

    task automatic wait_start(input bit wr, input string tag);
        int n = 0;
        logic [CNT_W-1:0] e;
        while (!(wr ? start_wr : start_rd) && n < 100) begin
            step();
            n++;
        end
        check({tag, "_pulse"}, wr ? start_wr : start_rd, 1);
        check({tag, "_sb"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, exec_count, e);
        end
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; opcode = 3'd0; count = '0;
        done_rd = 1'b0; done_wr = 1'b0; done_delay = 1'b0; pass_cmp = 1'b0;
        intr_edge = 1'b0; resume = 1'b0; err_clr = 1'b0;

        #22;
        check("rst_outs", outs_vec(), 0);
        check("rst_cnt", exec_count, 0);
        check("rst_state", state_dbg, 0);
        step();
        rst_n = 1'b1;
        step();

        // NOP with enable held: en_pc cycle 1, START cycle 3, done_instr cycle 4, IDLE cycle 5
        opcode = 3'b000;
        enable = 1'b1;
        step(); check("nop_c1_enpc", en_pc, 1); check("nop_c1_st", state_dbg, 1);
        step(); check("nop_c2_st", state_dbg, 2); check("nop_c2_enpc", en_pc, 0);
        step(); check("nop_c3_st", state_dbg, 3);
        step(); check("nop_c4_done", done_instr, 1); check("nop_c4_st", state_dbg, 7);
        enable = 1'b0;
        step(); check("nop_c5_st", state_dbg, 0); check("nop_c5_done", done_instr, 0);

        // READ x3, done_rd about 5 cycles after each launch
        rd_pulses = 0;
        opcode = 3'b001; count = 7'd3;
        exp_q.push_back(7'd3); exp_q.push_back(7'd2); exp_q.push_back(7'd1);
        pulse_enable();
        for (int i = 0; i < 3; i++) begin
            wait_start(1'b0, "rd_cnt");
            repeat (4) step();
            done_rd = 1'b1;
            step();
            done_rd = 1'b0;
        end
        wait_state(4'd7, "rd_done_st");
        check("rd_done_pulse", done_instr, 1);
        check("rd_cnt_end", exec_count, 0);
        check("rd_pulses", rd_pulses, 3);
        step();

        // WRITE with count 0 executes exactly once
        wr_pulses = 0;
        opcode = 3'b010; count = 7'd0;
        exp_q.push_back(7'd0);
        pulse_enable();
        wait_start(1'b1, "wr0_cnt");
        repeat (2) step();
        done_wr = 1'b1;
        step();
        done_wr = 1'b0;
        wait_state(4'd7, "wr0_done_st");
        check("wr0_pulses", wr_pulses, 1);
        step();

        // DELAY: delay counter enabled through EXEC
        opcode = 3'b100;
        pulse_enable();
        wait_state(4'd4, "dly_exec_st");
        check("dly_en", en_delay_count, 1);
        check("dly_memrd", en_mem_rd, 1);
        done_delay = 1'b1;
        step();
        done_delay = 1'b0;
        check("dly_done_st", state_dbg, 7);
        step();

        // COMPARE count=2 that never passes: two launches, then retry error
        rd_pulses = 0;
        opcode = 3'b101; count = 7'd2; pass_cmp = 1'b0;
        exp_q.push_back(7'd2); exp_q.push_back(7'd1);
        pulse_enable();
        for (int i = 0; i < 2; i++) begin
            wait_start(1'b0, "cmp_cnt");
            repeat (2) step();
            done_rd = 1'b1;
            step();
            done_rd = 1'b0;
        end
        wait_state(4'd9, "cmp_err_st");
        check("cmp_err_retry", err_retry, 1);
        check("cmp_err_tmo", err_timeout, 0);
        check("cmp_pulses", rd_pulses, 2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("cmp_clr_done", done_instr, 1);
        check("cmp_clr_flag", err_retry, 0);
        step();
        check("cmp_idle", state_dbg, 0);

        // WAIT without interrupt: watchdog fires on the 20th FLAG_CHECK cycle
        opcode = 3'b110;
        pulse_enable();
        wait_state(4'd6, "wt_flag_st");
        repeat (19) step();
        check("wt_19_st", state_dbg, 6);
        check("wt_19_tmo", err_timeout, 0);
        step();
        check("wt_20_st", state_dbg, 9);
        check("wt_20_tmo", err_timeout, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("wt_clr_done", done_instr, 1);
        check("wt_clr_flag", err_timeout, 0);
        step();

        // WAIT with interrupt at FLAG_CHECK cycle 5
        pulse_enable();
        wait_state(4'd6, "wi_flag_st");
        repeat (4) step();
        intr_edge = 1'b1;
        step();
        intr_edge = 1'b0;
        check("wi_done_st", state_dbg, 7);
        check("wi_tmo", err_timeout, 0);
        step();

        // HALT holds until resume; stray done pulses are ignored
        opcode = 3'b111;
        pulse_enable();
        wait_state(4'd8, "ht_st");
        repeat (40) step();
        check("ht_halted", halted, 1);
        check("ht_busy", busy, 1);
        done_rd = 1'b1;
        step();
        done_rd = 1'b0;
        check("ht_stray", state_dbg, 8);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("ht_res_done", done_instr, 1);
        check("ht_res_halted", halted, 0);
        step();
        check("ht_idle", state_dbg, 0);

        // Asynchronous reset in the middle of a READ x4
        opcode = 3'b001; count = 7'd4;
        exp_q.push_back(7'd4);
        enable = 1'b1;
        wait_start(1'b0, "rs_cnt");
        step();
        check("rs_exec_st", state_dbg, 4);
        #2 rst_n = 1'b0;
        #1;
        check("rs_async_outs", outs_vec(), 0);
        check("rs_async_cnt", exec_count, 0);
        check("rs_async_st", state_dbg, 0);
        opcode = 3'b000;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rs_restart_st", state_dbg, 1);
        check("rs_restart_enpc", en_pc, 1);
        enable = 1'b0;
        wait_state(4'd7, "rs_nop_done");
        step();
        check("rs_idle", state_dbg, 0);

        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_seq_fsm_v2.md
Name: instr_seq_fsm_v2

Overview:
Parametrised next-generation instruction sequencer for the AXI command engine. It fetches one instruction per pass from program memory and issues read, write, delay, compare and wait operations to the AXI master and the delay counter. It adds parametrised count and fetch latency, a watchdog timeout on every wait, bounded compare retries, a HALT/resume opcode and sticky error reporting. It sits between the program counter/instruction RAM and the AXI read/write engines.

Parameters:
CNT_W, 7, width of instruction repeat count and exec_count
FETCH_LAT, 1, cycles from en_pc pulse to valid opcode/count (>=1)
TMO_W, 16, width of watchdog counter
TMO_CYCLES, 1000, watchdog limit in cycles; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; sequencer leaves IDLE only while high
opcode  in  3  instruction opcode from instruction RAM
count  in  CNT_W  repeat count (001/010) or retry budget (101)
done_rd  in  1  AXI read complete pulse
done_wr  in  1  AXI write complete pulse
done_delay  in  1  delay counter expired pulse
pass_cmp  in  1  compare result, valid in FLAG_CHECK
intr_edge  in  1  interrupt falling-edge pulse
resume  in  1  releases HALT
err_clr  in  1  clears error flags, leaves ERROR
start_rd  out  1  one-cycle read launch
start_wr  out  1  one-cycle write launch
en_mem_rd  out  1  data-memory read enable during EXEC
en_pc  out  1  one-cycle program-counter advance
en_delay_count  out  1  delay counter enable
exec_count  out  CNT_W  remaining executions/retries
done_instr  out  1  one-cycle instruction-retired pulse
busy  out  1  high in any state except IDLE
halted  out  1  high in HALT
err_timeout  out  1  sticky watchdog error
err_retry  out  1  sticky compare-retry-exhausted error
state_dbg  out  4  current state encoding

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; all outputs 0; exec_count 0; op_q/timer/fetch counter 0. Launches in flight are abandoned.
- Outputs are Moore-decoded from the state register and the latched op_q.
- States and encodings: IDLE 0, FETCH 1, WAIT_FETCH 2, START 3, EXEC 4, COUNT_CHECK 5, FLAG_CHECK 6, DONE 7, HALT 8, ERROR 9.
- IDLE -> FETCH when enable=1, else stay.
- FETCH: en_pc=1 for one cycle -> WAIT_FETCH. The fetch counter loads FETCH_LAT.
- WAIT_FETCH: counter decrements each cycle. At 1, latch opcode into op_q and go to START. If op_q is 001, 010 or 101, load count into exec_count on the same edge.
- START (one cycle): timer cleared.
  - 001: start_rd=1 -> EXEC.
  - 010: start_wr=1 -> EXEC.
  - 011: start_wr=1 -> EXEC.
  - 100: en_delay_count=1 -> EXEC.
  - 101: start_rd=1 -> EXEC.
  - 110 -> FLAG_CHECK.
  - 111 -> HALT.
  - 000 -> DONE.
- EXEC: en_mem_rd=1; en_delay_count=1 if op_q=100. Timer increments each cycle.
  - done_x = done_rd|done_wr|done_delay.
  - On done_x, exec_count decrements, saturating at 0 (001/010/101 only).
  - On done_x, next state: 001/010 -> COUNT_CHECK; 011/100 -> DONE; 101 -> FLAG_CHECK.
  - If timer reaches TMO_CYCLES (when TMO_CYCLES != 0) with no done_x: set err_timeout -> ERROR.
  - done_x and timeout in the same cycle: done wins.
- COUNT_CHECK: exec_count != 0 -> START, else DONE. count=0 therefore executes once, identical to count=1.
- FLAG_CHECK, op 101: pass_cmp=1 -> DONE; else exec_count != 0 -> START (retry); else set err_retry -> ERROR.
- FLAG_CHECK, op 110: timer runs. intr_edge -> DONE; on timeout set err_timeout -> ERROR. intr_edge wins over timeout.
- HALT: halted=1; resume -> DONE. No timeout applies.
- ERROR: outputs idle; error flags held. err_clr -> clear both flags, -> DONE, so the program advances past the faulting instruction.
- DONE: done_instr=1 for one cycle -> IDLE.
- Timer: width TMO_W, saturating; compares with ==TMO_CYCLES.
- Unused done_* pulses outside EXEC are ignored. They do not decrement exec_count.

Test Plan:
- NOP (000), FETCH_LAT=1, enable held high: en_pc at cycle 1, START at cycle 3, done_instr at cycle 4, back to IDLE at cycle 5.
- READ 001 count=3, done_rd 5 cycles after each start_rd: exactly 3 start_rd pulses, exec_count 3->2->1->0, then one done_instr.
- COMPARE 101 count=2, pass_cmp=0 always: 2 start_rd pulses, then err_retry=1, state ERROR. err_clr -> done_instr, flags 0.
- WAIT 110, TMO_CYCLES=20, no intr_edge: err_timeout=1 after 20 cycles in FLAG_CHECK. Repeat with intr_edge at cycle 5 -> DONE, no error.
- HALT 111: halted=1 and busy=1 indefinitely; resume pulse -> done_instr next cycle, halted=0.
- Reset mid-EXEC of 001 count=4: rst_n low -> all outputs 0 and exec_count 0 immediately, without waiting for a clock edge; after release the sequencer restarts at FETCH with enable=1.
